// File: rtl/wave_rom_scheduler_if.sv
// Channel/ROM bus of the waveform ROM scheduler: requester controls, ROM port and sample return.
interface wave_rom_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int TABLE_BITS = 2,
    parameter int N_CH       = 4
);
    localparam int IDX_W = ADDR_WIDTH - TABLE_BITS;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]            req;
    logic [N_CH*TABLE_BITS-1:0] sel;
    logic [N_CH*IDX_W-1:0]      step;
    logic [N_CH-1:0]            clr;
    logic [N_CH-1:0]            gnt;
    logic                       rom_en;
    logic [ADDR_WIDTH-1:0]      rom_addr;
    logic [DATA_WIDTH-1:0]      rom_data;
    logic                       smp_valid;
    logic [DATA_WIDTH-1:0]      smp_data;
    logic [CH_W-1:0]            smp_ch;
    logic                       busy;

    modport master (
        output req, sel, step, clr, rom_data,
        input  gnt, rom_en, rom_addr, smp_valid, smp_data, smp_ch, busy
    );

    modport slave (
        input  req, sel, step, clr, rom_data,
        output gnt, rom_en, rom_addr, smp_valid, smp_data, smp_ch, busy
    );
endinterface

// File: rtl/wave_rom_scheduler.sv
// Round-robin sharing of one waveform ROM among N_CH phase-accumulator channels.
// Define WAVE_SCHED_CH0_PRIO_EN to give channel 0 fixed top priority.
module wave_rom_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int TABLE_BITS = 2,
    parameter int N_CH       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wave_rom_scheduler_if.slave  bus
);
    localparam int IDX_W = ADDR_WIDTH - TABLE_BITS;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [IDX_W-1:0]      ph [N_CH];
    logic [CH_W-1:0]       rr;
    logic [CH_W-1:0]       issue_ch;

    logic [N_CH-1:0]       gnt_q;
    logic                  rom_en_q;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic                  smp_valid_q;
    logic [DATA_WIDTH-1:0] smp_data_q;
    logic [CH_W-1:0]       smp_ch_q;

    logic                  hit;
    logic [CH_W-1:0]       g;
    logic [CH_W-1:0]       cand;
    logic [TABLE_BITS-1:0] sel_g;
    logic [IDX_W-1:0]      step_g;
    logic [IDX_W-1:0]      idx_g;
    int unsigned           c;

    // Cyclic search from rr+1; the first requester found wins.
    always_comb begin
        hit  = 1'b0;
        g    = '0;
        c    = 0;
        cand = '0;
`ifdef WAVE_SCHED_CH0_PRIO_EN
        if (bus.req[0]) begin
            hit = 1'b1;
        end
`endif
        for (int unsigned k = 1; k <= N_CH; k++) begin
            c    = (32'(rr) + k) % N_CH;
            cand = CH_W'(c);
`ifdef WAVE_SCHED_CH0_PRIO_EN
            if (!hit && (cand != '0) && bus.req[cand]) begin
`else
            if (!hit && bus.req[cand]) begin
`endif
                hit = 1'b1;
                g   = cand;
            end
        end
        sel_g  = bus.sel[g*TABLE_BITS +: TABLE_BITS];
        step_g = bus.step[g*IDX_W +: IDX_W];
        idx_g  = bus.clr[g] ? '0 : ph[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            smp_valid_q <= 1'b0;
            smp_data_q  <= '0;
            smp_ch_q    <= '0;
            issue_ch    <= '0;
            rr          <= CH_W'(N_CH - 1);
            for (int unsigned i = 0; i < N_CH; i++) begin
                ph[i] <= '0;
            end
        end else begin
            rom_en_q    <= hit;
            smp_valid_q <= rom_en_q;
            if (rom_en_q) begin
                smp_data_q <= bus.rom_data;
                smp_ch_q   <= issue_ch;
            end
            gnt_q <= hit ? (N_CH'(1) << g) : '0;
            if (hit) begin
                rom_addr_q <= {sel_g, idx_g};
                issue_ch   <= g;
`ifdef WAVE_SCHED_CH0_PRIO_EN
                if (g != '0) begin
                    rr <= g;
                end
`else
                rr <= g;
`endif
            end
            // A clear on the granted channel is already folded into idx_g.
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (hit && (g == CH_W'(i))) begin
                    ph[i] <= idx_g + step_g;
                end else if (bus.clr[i]) begin
                    ph[i] <= '0;
                end
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rom_en    = rom_en_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.smp_valid = smp_valid_q;
    assign bus.smp_data  = smp_data_q;
    assign bus.smp_ch    = smp_ch_q;
    assign bus.busy      = rom_en_q | smp_valid_q;
endmodule
